// File: rtl/shiftreg_chain_if.sv
// Word handshake between system logic and the 74HC595 chain driver.
// The driver takes the slave side; i_/o_ prefixes are from the driver's point of view.
interface shiftreg_chain_if #(
    parameter int W = 16
);
    logic [W-1:0] i_Data;
    logic         i_Valid;
    logic         o_Ready;
    logic         o_Done;

    modport master (
        output i_Data,
        output i_Valid,
        input  o_Ready,
        input  o_Done
    );

    modport slave (
        input  i_Data,
        input  i_Valid,
        output o_Ready,
        output o_Done
    );
endinterface

// File: rtl/shiftreg_chain.sv
// 74HC595 daisy-chain driver: shifts 8*N_REGS bits out on SER/SRCLK, then pulses RCLK.
// Define SHIFTREG_OE_EN to add o_OE_n, held high until the first completed transfer.
module shiftreg_chain #(
    parameter int N_REGS    = 2,
    parameter int DIV       = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    shiftreg_chain_if.slave   bus,
    output logic              o_SRCLK,
    output logic              o_RCLK,
`ifdef SHIFTREG_OE_EN
    output logic              o_SER,
    output logic              o_OE_n
`else
    output logic              o_SER
`endif
);

    localparam int W   = 8 * N_REGS;
    localparam int BCW = $clog2(W + 1);
    localparam int DCW = $clog2(DIV + 1);

    localparam logic [BCW-1:0] BIT_LAST = BCW'(W - 1);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);

    generate
        if (N_REGS < 1 || DIV < 1) begin : g_param_check
            $error("shiftreg_chain: N_REGS and DIV must both be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LATCH_GAP,
        S_LATCH_HI,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_shreg;
    logic [BCW-1:0] r_bit_cnt;
    logic [DCW-1:0] r_div_cnt;
    logic           r_ready;
    logic           r_done;
    logic           r_srclk;
    logic           r_rclk;
    logic           r_ser;

    logic           w_accept;
    logic           w_phase_end;
    logic           w_load_head;
    logic [W-1:0]   w_shifted;
    logic           w_shift_head;

    // r_ready is high only in IDLE and DONE, so a word can also be taken in DONE.
    assign w_accept     = r_ready & bus.i_Valid;
    assign w_phase_end  = (r_div_cnt == DIV_LAST);
    assign w_load_head  = MSB_FIRST ? bus.i_Data[W-1] : bus.i_Data[0];
    assign w_shifted    = MSB_FIRST ? {r_shreg[W-2:0], 1'b0} : {1'b0, r_shreg[W-1:1]};
    assign w_shift_head = MSB_FIRST ? w_shifted[W-1] : w_shifted[0];

    // NOTE: reset is sampled on the clock edge, and every register here (the data
    // shift register included) gets a known value; all state updates are non-blocking.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_srclk   <= 1'b0;
            r_rclk    <= 1'b0;
            r_ser     <= 1'b0;
        end else if (w_accept) begin
            r_state   <= S_SHIFT_LO;
            r_shreg   <= bus.i_Data;
            r_ser     <= w_load_head;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_ready   <= 1'b0;
            r_done    <= 1'b0;
            r_srclk   <= 1'b0;
            r_rclk    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                end
                S_SHIFT_LO: begin
                    if (w_phase_end) begin
                        r_div_cnt <= '0;
                        r_srclk   <= 1'b1;
                        r_state   <= S_SHIFT_HI;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                S_SHIFT_HI: begin
                    if (w_phase_end) begin
                        r_div_cnt <= '0;
                        r_srclk   <= 1'b0;
                        if (r_bit_cnt == BIT_LAST) begin
                            // SER keeps the last bit until the next word's first bit.
                            r_state <= S_LATCH_GAP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shreg   <= w_shifted;
                            r_ser     <= w_shift_head;
                            r_state   <= S_SHIFT_LO;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                S_LATCH_GAP: begin
                    if (w_phase_end) begin
                        r_div_cnt <= '0;
                        r_rclk    <= 1'b1;
                        r_state   <= S_LATCH_HI;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                S_LATCH_HI: begin
                    if (w_phase_end) begin
                        r_div_cnt <= '0;
                        r_rclk    <= 1'b0;
                        r_done    <= 1'b1;
                        r_ready   <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_done  <= 1'b0;
                    r_srclk <= 1'b0;
                    r_rclk  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHIFTREG_OE_EN
    logic r_oe_n;

    // Outputs stay tri-stated until the chain holds a word this driver latched.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_oe_n <= 1'b1;
        end else if (r_state == S_LATCH_HI && w_phase_end) begin
            r_oe_n <= 1'b0;
        end
    end

    assign o_OE_n = r_oe_n;
`endif

    assign bus.o_Ready = r_ready;
    assign bus.o_Done  = r_done;
    assign o_SRCLK     = r_srclk;
    assign o_RCLK      = r_rclk;
    assign o_SER       = r_ser;

endmodule
